turn_signal_sequencer: RTL

//  Sequences the six tail lamps of the TurnSignal design: 3-step left/right sweep and hazard flash.

---
 rtl/turn_signal_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/turn_signal_sequencer.sv
// turn_signal_sequencer
//   Drives the six tail lamps of the TurnSignal design: a 3-step sweep for
//   left/right turns and an all-on/all-off hazard flash. A free-running
//   prescaler divides clock_in into a one-cycle step_tick enable; the lamp FSM
//   only advances on that enable, so no derived clock exists.
//
// Optional build macro TICK_EXT_EN:
//   defined   -> adds port tick_in, drops the prescaler; step_tick = tick_in & reset_n
//   undefined -> internal prescaler of TICK_DIV cycles (default build)
//
// Ports
//   clock_in     in   1  board clock, all logic on posedge
//   reset_n      in   1  synchronous active-low reset
//   left_req     in   1  left-turn switch level (synchronised)
//   right_req    in   1  right-turn switch level (synchronised)
//   hazard_req   in   1  hazard switch level (synchronised)
//   tick_in      in   1  external step enable (TICK_EXT_EN builds only)
//   left_lamps   out  3  left lamps, bit0 innermost, registered
//   right_lamps  out  3  right lamps, bit0 innermost, registered
//   step_tick    out  1  one-cycle pulse when the FSM may advance
//
// State  | meaning
// -------+------------------------------------------------
// IDLE   | all lamps off, waiting for a request
// L1..L3 | left sweep, 1/2/3 lamps lit
// R1..R3 | right sweep, 1/2/3 lamps lit
// HON    | hazard flash, all six lamps lit
// HOFF   | hazard flash, all lamps off
module turn_signal_sequencer #(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
`ifdef TICK_EXT_EN
  input  logic       tick_in,
`endif
  output logic [2:0] left_lamps,
  output logic [2:0] right_lamps,
  output logic       step_tick
);

  typedef enum logic [3:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HON, S_HOFF
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE, REQ_LEFT, REQ_RIGHT, REQ_HAZ
  } req_e;

  state_e state;
  state_e state_nxt;
  req_e   eff_req;

`ifdef TICK_EXT_EN
  assign step_tick = tick_in & reset_n;
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Gated with reset_n so the tick can never fire in a reset cycle.
  assign step_tick = reset_n & (count == CNT_LAST);
`endif

  function automatic logic [2:0] left_pattern(input state_e s);
    case (s)
      S_L1:       left_pattern = 3'b001;
      S_L2:       left_pattern = 3'b011;
      S_L3, S_HON: left_pattern = 3'b111;
      default:    left_pattern = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] right_pattern(input state_e s);
    case (s)
      S_R1:       right_pattern = 3'b001;
      S_R2:       right_pattern = 3'b011;
      S_R3, S_HON: right_pattern = 3'b111;
      default:    right_pattern = 3'b000;
    endcase
  endfunction

  // Both turn switches at once are treated as a hazard request.
  always_comb begin
    eff_req = REQ_NONE;
    if (hazard_req || (left_req && right_req)) begin
      eff_req = REQ_HAZ;
    end else if (left_req) begin
      eff_req = REQ_LEFT;
    end else if (right_req) begin
      eff_req = REQ_RIGHT;
    end
  end

  // Any change of direction from a sweep goes through IDLE first, which
  // guarantees one all-off step between unrelated patterns.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        case (eff_req)
          REQ_HAZ:   state_nxt = S_HON;
          REQ_LEFT:  state_nxt = S_L1;
          REQ_RIGHT: state_nxt = S_R1;
          default:   state_nxt = S_IDLE;
        endcase
      end
      S_L1:    state_nxt = (eff_req == REQ_LEFT)  ? S_L2 : S_IDLE;
      S_L2:    state_nxt = (eff_req == REQ_LEFT)  ? S_L3 : S_IDLE;
      S_L3:    state_nxt = S_IDLE;
      S_R1:    state_nxt = (eff_req == REQ_RIGHT) ? S_R2 : S_IDLE;
      S_R2:    state_nxt = (eff_req == REQ_RIGHT) ? S_R3 : S_IDLE;
      S_R3:    state_nxt = S_IDLE;
      S_HON:   state_nxt = S_HOFF;
      S_HOFF:  state_nxt = (eff_req == REQ_HAZ)   ? S_HON : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      left_lamps  <= 3'b000;
      right_lamps <= 3'b000;
    end else if (step_tick) begin
      state       <= state_nxt;
      left_lamps  <= left_pattern(state_nxt);
      right_lamps <= right_pattern(state_nxt);
    end
  end

endmodule
